// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit among four requesters with a round-robin grant.
// A two-state FSM accepts one operation in IDLE and holds its result in BUSY until it is consumed.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    output logic [3:0]           req_ready,
    input  logic [11:0]          req_op,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     rsp_y,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [1:0]         last_grant;
    logic [1:0]         win_id;
    logic [1:0]         idx;
    logic               win_any;
    logic [2:0]         op_p1;
    logic [WIDTH-1:0]   a_p1;
    logic [WIDTH-1:0]   b_p1;
    logic [1:0]         id_p1;

    // Result is {err, y}; the reserved opcode yields zero with the error flag set.
    function automatic logic [WIDTH:0] logic_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            3'b000:  r = {1'b0, a & b};
            3'b001:  r = {1'b0, a | b};
            3'b010:  r = {1'b0, ~a};
            3'b011:  r = {1'b0, a ^ b};
            3'b100:  r = {1'b0, ~(a & b)};
            3'b101:  r = {1'b0, ~(a | b)};
            3'b110:  r = {1'b0, ~(a ^ b)};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_any = 1'b0;
        win_id  = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = last_grant + 2'd1 + 2'(k);
            if (!win_any && req_valid[idx]) begin
                win_any = 1'b1;
                win_id  = idx;
            end
        end
    end

    assign req_ready = (state == IDLE && win_any) ? (4'b0001 << win_id) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            op_p1      <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            id_p1      <= '0;
        end else if (state == IDLE) begin
            if (win_any) begin
                op_p1      <= req_op[3*win_id +: 3];
                a_p1       <= req_a[WIDTH*win_id +: WIDTH];
                b_p1       <= req_b[WIDTH*win_id +: WIDTH];
                id_p1      <= win_id;
                last_grant <= win_id;
                state      <= BUSY;
            end
        end else begin
            if (rsp_ready) begin
                state <= IDLE;
            end
        end
    end

    // Stage p1: response derived from the registered operands.
    assign rsp_valid          = (state == BUSY);
    assign busy               = (state == BUSY);
    assign rsp_id             = id_p1;
    assign {rsp_err, rsp_y}   = logic_op(op_p1, a_p1, b_p1);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares each consumed response.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           req_valid;
    logic [3:0]           req_ready;
    logic [11:0]          req_op;
    logic [4*WIDTH-1:0]   req_a;
    logic [4*WIDTH-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [WIDTH-1:0]     rsp_y;
    logic                 rsp_err;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    logic [10:0] sb[$];  // {id[1:0], y[7:0], err}

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d y=%0h with empty scoreboard", rsp_id, rsp_y);
            end else begin
                automatic logic [10:0] e = sb.pop_front();
                chk("rsp_id",  32'(rsp_id),  32'(e[10:9]));
                chk("rsp_y",   32'(rsp_y),   32'(e[8:1]));
                chk("rsp_err", 32'(rsp_err), 32'(e[0]));
            end
        end
    end

    task automatic set_slot(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    // One isolated request with rsp_ready held high.
    task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] y, input logic err);
        @(posedge clk); #1;
        set_slot(id, op, a, b);
        req_valid = 4'(1 << id);
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'(1 << id));
        sb.push_back({2'(id), y, err});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("latency_valid", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sweep_y [8];
        int order [5];
        logic [7:0] fair_y [4];
        sweep_y = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h00};
        order   = '{0, 1, 2, 3, 0};
        fair_y  = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};

        rst = 1'b1; req_valid = 4'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_y",     32'(rsp_y),     32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single request and opcode sweep.
        rsp_ready = 1'b1;
        issue(0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0);
        for (int op = 0; op < 8; op++)
            issue(2, 3'(op), 8'hA5, 8'h0F, sweep_y[op], (op == 7));

        // Fairness: put last_grant at 3, then hold all four requests.
        issue(3, 3'b000, 8'hFF, 8'h81, 8'h81, 1'b0);
        @(posedge clk); #1;
        req_op = 12'b011_011_011_011;
        req_a  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_b  = {4{8'hFF}};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("fair_grant", 32'(req_ready), 32'(1 << order[g]));
            sb.push_back({2'(order[g]), fair_y[order[g]], 1'b0});
            @(negedge clk);
            chk("fair_busy_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;

        // Backpressure on requester 1 while everyone else waits.
        rsp_ready = 1'b0;
        req_op = {4{3'b100}};
        req_a  = {4{8'hCC}};
        req_b  = {4{8'hAA}};
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'b0010);
        sb.push_back({2'd1, 8'h77, 1'b0});
        @(posedge clk); #1;
        req_valid = 4'b1111;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_y",     32'(rsp_y),     32'h77);
            chk("bp_id",    32'(rsp_id),    32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        sb.push_back({2'd2, 8'h77, 1'b0});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;

        // Reset while BUSY discards the pending result.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("rst_mid_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy",  32'(busy),      32'd0);
        chk("rst_mid_grant0", 32'(req_ready), 32'b0001);
        sb.push_back({2'd0, 8'h77, 1'b0});
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
